// File: rtl/ham_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ham_ram_ctrl
//  Description : Two-requester round-robin controller for a Hamming(12,8)
//                protected word array with single-bit correction.
//  Revision    : 1.0
// ============================================================================
module ham_ram_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_req_valid,
    input  logic [1:0]            i_req_we,
    input  logic [2*ADDR_W-1:0]   i_req_addr,
    input  logic [15:0]           i_req_wdata,
    output logic [1:0]            o_req_ready,
    output logic [1:0]            o_wack,
    output logic [1:0]            o_rvalid,
    output logic [7:0]            o_rdata,
    output logic                  o_err_corr,
    output logic                  o_err_bad,
    input  logic                  i_inj_en,
    input  logic [3:0]            i_inj_bit,
    output logic [11:0]           o_last_code
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [2:0] C_ST_IDLE = 3'd0;
    localparam logic [2:0] C_ST_ENC  = 3'd1;
    localparam logic [2:0] C_ST_WR   = 3'd2;
    localparam logic [2:0] C_ST_RD   = 3'd3;
    localparam logic [2:0] C_ST_DEC  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              pref_q;
    logic              sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              inj_q;
    logic [3:0]        inj_bit_q;
    logic [11:0]       code_q;
    logic [11:0]       last_code_q;
    logic [7:0]        rdata_q;
    logic              corr_q;
    logic              bad_q;
    logic [1:0]        rvalid_q;
    logic [11:0]       mem_q [DEPTH];

    logic              w_gnt_idx;
    logic              w_gnt_we;
    logic              w_take;
    logic [11:0]       w_enc;
    logic [11:0]       w_inj_mask;
    logic [3:0]        w_syn;
    logic [11:0]       w_fix;
    logic [7:0]        w_dec_data;
    logic              w_corr;
    logic              w_bad;

    // Contention goes to the preferred requester; a lone requester always wins.
    always_comb begin
        if (i_req_valid == 2'b11) begin
            w_gnt_idx = pref_q;
        end else begin
            w_gnt_idx = i_req_valid[1];
        end
        w_gnt_we = w_gnt_idx ? i_req_we[1] : i_req_we[0];
        w_take   = (state_q == C_ST_IDLE) && (|i_req_valid);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: if (w_take) state_d = w_gnt_we ? C_ST_ENC : C_ST_RD;
            C_ST_ENC:  state_d = C_ST_WR;
            C_ST_WR:   state_d = C_ST_IDLE;
            C_ST_RD:   state_d = C_ST_DEC;
            C_ST_DEC:  state_d = C_ST_IDLE;
            default:   state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = 2'b00;
        o_wack      = 2'b00;
        if (w_take) begin
            o_req_ready = w_gnt_idx ? 2'b10 : 2'b01;
        end
        if (state_q == C_ST_WR) begin
            o_wack = {sel_q, ~sel_q};
        end
    end

    always_comb begin
        w_enc[0]   = wdata_q[0] ^ wdata_q[1] ^ wdata_q[3] ^ wdata_q[4] ^ wdata_q[6];
        w_enc[1]   = wdata_q[0] ^ wdata_q[2] ^ wdata_q[3] ^ wdata_q[5] ^ wdata_q[6];
        w_enc[2]   = wdata_q[0];
        w_enc[3]   = wdata_q[1] ^ wdata_q[2] ^ wdata_q[3] ^ wdata_q[7];
        w_enc[6:4] = wdata_q[3:1];
        w_enc[7]   = wdata_q[4] ^ wdata_q[5] ^ wdata_q[6] ^ wdata_q[7];
        w_enc[11:8] = wdata_q[7:4];
        w_inj_mask = inj_q ? (12'b1 << inj_bit_q) : 12'b0;
    end

    // Syndrome masks select the codeword bits whose Hamming position has bit k set.
    always_comb begin
        w_syn[0] = ^(code_q & 12'h555);
        w_syn[1] = ^(code_q & 12'h666);
        w_syn[2] = ^(code_q & 12'h878);
        w_syn[3] = ^(code_q & 12'hF80);
        w_corr   = (w_syn != 4'd0) && (w_syn <= 4'd12);
        w_bad    = (w_syn >= 4'd13);
        w_fix    = code_q;
        if (w_corr) begin
            w_fix = code_q ^ (12'b1 << (w_syn - 4'd1));
        end
        w_dec_data = {w_fix[11:8], w_fix[6:4], w_fix[2]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pref_q      <= 1'b0;
            sel_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            inj_q       <= 1'b0;
            inj_bit_q   <= 4'd0;
            code_q      <= 12'h000;
            last_code_q <= 12'h000;
            rdata_q     <= 8'h00;
            corr_q      <= 1'b0;
            bad_q       <= 1'b0;
            rvalid_q    <= 2'b00;
        end else begin
            rvalid_q <= 2'b00;
            if (w_take) begin
                pref_q    <= ~w_gnt_idx;
                sel_q     <= w_gnt_idx;
                addr_q    <= w_gnt_idx ? i_req_addr[2*ADDR_W-1:ADDR_W] : i_req_addr[ADDR_W-1:0];
                wdata_q   <= w_gnt_idx ? i_req_wdata[15:8] : i_req_wdata[7:0];
                inj_q     <= i_inj_en && (i_inj_bit < 4'd12);
                inj_bit_q <= i_inj_bit;
            end
            case (state_q)
                C_ST_ENC: code_q <= w_enc ^ w_inj_mask;
                C_ST_WR:  last_code_q <= code_q;
                C_ST_RD:  code_q <= mem_q[addr_q];
                C_ST_DEC: begin
                    rdata_q  <= w_dec_data;
                    corr_q   <= w_corr;
                    bad_q    <= w_bad;
                    rvalid_q <= {sel_q, ~sel_q};
                end
                default: ;
            endcase
        end
    end

    // Array has no reset; contents survive controller reset.
    always_ff @(posedge i_clk) begin
        if (state_q == C_ST_WR) begin
            mem_q[addr_q] <= code_q;
        end
    end

    assign o_rvalid    = rvalid_q;
    assign o_rdata     = rdata_q;
    assign o_err_corr  = corr_q;
    assign o_err_bad   = bad_q;
    assign o_last_code = last_code_q;

endmodule
`default_nettype wire

// File: tb/tb_ham_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ham_ram_ctrl
//  Description : Self-checking bench for ham_ram_ctrl with a positional
//                Hamming reference model.
//  Revision    : 1.0
// ============================================================================
module tb_ham_ram_ctrl;

    localparam int ADDR_W = 4;
    localparam int DPOS [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_we = '0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        inj_en = 1'b0;
    logic [3:0]  inj_bit = '0;
    logic [1:0]  req_ready, wack, rvalid;
    logic [7:0]  rdata;
    logic        err_corr, err_bad;
    logic [11:0] last_code;

    int n_pass = 0;
    int n_chk  = 0;
    logic [11:0] mem_m [16];
    logic [11:0] last_m = 12'h000;

    ham_ram_ctrl #(.ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_req_ready(req_ready),
        .o_wack(wack), .o_rvalid(rvalid), .o_rdata(rdata), .o_err_corr(err_corr),
        .o_err_bad(err_bad), .i_inj_en(inj_en), .i_inj_bit(inj_bit),
        .o_last_code(last_code)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] syn_of(input logic [11:0] cw);
        logic [3:0] s = 4'd0;
        for (int i = 0; i < 12; i++) if (cw[i]) s = s ^ 4'(i + 1);
        return s;
    endfunction

    // Data at non-power-of-two positions; parity positions chosen to zero the syndrome.
    function automatic logic [11:0] enc(input logic [7:0] d);
        logic [11:0] cw = 12'h000;
        logic [3:0]  s;
        for (int j = 0; j < 8; j++) if (d[j]) cw[DPOS[j]-1] = 1'b1;
        s = syn_of(cw);
        for (int k = 0; k < 4; k++) if (s[k]) cw[(1 << k) - 1] = 1'b1;
        return cw;
    endfunction

    function automatic void dec(input logic [11:0] cw, output logic [7:0] d,
                                output logic c, output logic b);
        logic [3:0]  s = syn_of(cw);
        logic [11:0] f = cw;
        c = (s >= 4'd1) && (s <= 4'd12);
        b = (s >= 4'd13);
        if (c) f[s-1] = ~f[s-1];
        for (int j = 0; j < 8; j++) d[j] = f[DPOS[j]-1];
    endfunction

    task automatic do_op(input int n, input bit we, input logic [3:0] addr,
                         input logic [7:0] data, input bit ie, input logic [3:0] ib);
        logic [1:0]  oh;
        logic [1:0]  pulse;
        logic [7:0]  ed;
        logic        ec, eb;
        logic [11:0] cw;
        int          lat;
        bit          got;
        oh = (n != 0) ? 2'b10 : 2'b01;
        req_valid = oh; req_we = {we, we}; req_addr = {addr, addr};
        req_wdata = {data, data}; inj_en = ie; inj_bit = ib;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (req_ready !== 2'b00) got = 1;
        end
        n_chk++;
        if (req_ready !== oh) begin
            $display("FAIL grant: ready=%b expected=%b", req_ready, oh);
            @(posedge clk); #1 req_valid = 2'b00;
            return;
        end else n_pass++;
        @(posedge clk); #1 req_valid = 2'b00;
        if (we) begin
            cw = enc(data);
            if (ie && ib < 4'd12) cw[ib] = ~cw[ib];
            mem_m[addr] = cw;
            last_m = cw;
        end
        lat = 0; got = 0; pulse = 2'b00;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            pulse = we ? wack : rvalid;
            if (pulse !== 2'b00) begin got = 1; lat = c; end
        end
        n_chk++;
        if (lat != (we ? 2 : 3) || pulse !== oh) begin
            $display("FAIL latency: lat=%0d pulse=%b expected lat=%0d pulse=%b",
                     lat, pulse, we ? 2 : 3, oh);
        end else n_pass++;
        if (!we) begin
            dec(mem_m[addr], ed, ec, eb);
            n_chk++;
            if ({rdata, err_corr, err_bad} !== {ed, ec, eb}) begin
                $display("FAIL rdata: data=%h corr=%b bad=%b expected data=%h corr=%b bad=%b",
                         rdata, err_corr, err_bad, ed, ec, eb);
            end else n_pass++;
        end
        @(negedge clk);
        n_chk++;
        if ((we ? wack : rvalid) !== 2'b00) begin
            $display("FAIL pulse_width: pulse=%b expected=00", we ? wack : rvalid);
        end else n_pass++;
        n_chk++;
        if (we && last_code !== last_m) begin
            $display("FAIL last_code: got=%h expected=%h", last_code, last_m);
        end else if (!we && rdata !== ed) begin
            $display("FAIL rdata_hold: got=%h expected=%h", rdata, ed);
        end else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({req_ready, wack, rvalid, rdata, err_corr, err_bad, last_code} !== 28'h0) begin
            $display("FAIL reset_state: ready=%b wack=%b rvalid=%b rdata=%h corr=%b bad=%b last=%h expected all zero",
                     req_ready, wack, rvalid, rdata, err_corr, err_bad, last_code);
        end else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_op(0, 1, 4'd3, 8'h11, 0, 4'd0);
        n_chk++;
        if (last_code !== 12'h186) $display("FAIL code_0x11: got=%h expected=186", last_code);
        else n_pass++;
        do_op(1, 0, 4'd3, 8'h00, 0, 4'd0);
        n_chk++;
        if (rdata !== 8'h11 || err_corr !== 1'b0) $display("FAIL read_0x11: data=%h corr=%b expected 11/0", rdata, err_corr);
        else n_pass++;
        do_op(0, 1, 4'd5, 8'h11, 1, 4'd2);
        n_chk++;
        if (last_code !== 12'h182) $display("FAIL inject2_code: got=%h expected=182", last_code);
        else n_pass++;
        do_op(1, 0, 4'd5, 8'h00, 0, 4'd0);
        n_chk++;
        if (rdata !== 8'h11 || err_corr !== 1'b1) $display("FAIL inject2_read: data=%h corr=%b expected 11/1", rdata, err_corr);
        else n_pass++;
        do_op(0, 1, 4'd6, 8'h11, 1, 4'd15);
        n_chk++;
        if (last_code !== 12'h186) $display("FAIL inject15_code: got=%h expected=186", last_code);
        else n_pass++;
        do_op(0, 0, 4'd6, 8'h00, 0, 4'd0);
        n_chk++;
        if (err_corr !== 1'b0) $display("FAIL inject15_read: corr=%b expected=0", err_corr);
        else n_pass++;
    endtask

    task automatic test_fill_and_random();
        for (int a = 0; a < 16; a++) do_op(a % 2, 1, 4'(a), 8'($urandom), 0, 4'd0);
        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 4'($urandom),
                  8'($urandom), bit'($urandom_range(0, 1)), 4'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        do_op(1, 1, 4'd9, 8'hA5, 0, 4'd0);
        do_op(0, 0, 4'd9, 8'h00, 0, 4'd0);
        do_op(0, 1, 4'd9, 8'h3C, 1, 4'd11);
        do_op(1, 0, 4'd9, 8'h00, 0, 4'd0);
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_r;
        rst_n = 1'b0;
        req_valid = 2'b11; req_we = 2'b00; req_addr = {4'd3, 4'd5};
        last_m = 12'h000;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_r = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 != 0) ? 2'b10 : 2'b01);
            n_chk++;
            if (req_ready !== exp_r) $display("FAIL arb_cycle%0d: ready=%b expected=%b", c, req_ready, exp_r);
            else n_pass++;
        end
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_read();
        bit seen = 0;
        req_valid = 2'b01; req_we = 2'b00; req_addr = {4'd0, 4'd3};
        @(negedge clk);
        n_chk++;
        if (req_ready !== 2'b01) $display("FAIL abort_grant: ready=%b expected=01", req_ready);
        else n_pass++;
        @(posedge clk); #1 req_valid = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({req_ready, wack, rvalid, rdata, err_corr, err_bad, last_code} !== 28'h0) begin
            $display("FAIL async_reset: ready=%b wack=%b rvalid=%b rdata=%h corr=%b bad=%b last=%h expected all zero",
                     req_ready, wack, rvalid, rdata, err_corr, err_bad, last_code);
        end else n_pass++;
        last_m = 12'h000;
        req_valid = 2'b11; req_addr = {4'd3, 4'd3};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rvalid !== 2'b00) seen = 1;
        end
        @(posedge clk); #1 rst_n = 1'b1;
        n_chk++;
        if (seen) $display("FAIL abort_rvalid: rvalid seen=1 expected=0");
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 2'b01) $display("FAIL post_reset_grant: ready=%b expected=01", req_ready);
        else n_pass++;
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_fill_and_random();
        test_back_to_back();
        test_arbitration();
        test_reset_mid_read();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ham_ram_ctrl.md
HAM_RAM_CTRL -- requirements
Module: ham_ram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, address width; array depth SHALL be 2**ADDR_W words of 12 bits.
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_req_valid  input  2  per-requester request (bit n = requester n).
REQ-005 i_req_we  input  2  per-requester op: 1 = write, 0 = read.
REQ-006 i_req_addr  input  2*ADDR_W  requester n address in bits [n*ADDR_W +: ADDR_W].
REQ-007 i_req_wdata  input  16  requester n write byte in bits [n*8 +: 8].
REQ-008 o_req_ready  output  2  one-hot grant/accept strobe.
REQ-009 o_wack  output  2  one-cycle write-complete pulse to requester n.
REQ-010 o_rvalid  output  2  one-cycle read-data-valid pulse to requester n.
REQ-011 o_rdata  output  8  corrected read byte, valid with o_rvalid.
REQ-012 o_err_corr  output  1  single-bit error corrected, valid with o_rvalid.
REQ-013 o_err_bad  output  1  syndrome 13..15 (invalid), valid with o_rvalid.
REQ-014 i_inj_en  input  1  error injection enable, sampled at grant.
REQ-015 i_inj_bit  input  4  codeword bit index 0..11 to flip on write; values 12..15 inject nothing.
REQ-016 o_last_code  output  12  last codeword written to the array, post-injection.

Function
REQ-017 Controller SHALL be one FSM: IDLE, ENC, WR, RD, DEC.
REQ-018 IDLE: when any i_req_valid bit is set, the winner's o_req_ready bit SHALL assert combinationally that cycle; op, addr, data, inj fields SHALL be latched; next state ENC (write) or RD (read).
REQ-019 Arbitration: round-robin; if both valid, grant the requester not granted last; pointer reset value SHALL favour requester 0; a single valid requester always wins.
REQ-020 o_req_ready SHALL be 0 outside IDLE; requesters hold valid and fields stable until ready.
REQ-021 ENC: codeword computed and registered, even parity: p0=d0^d1^d3^d4^d6, p1=d0^d2^d3^d5^d6, p2=d1^d2^d3^d7, p3=d4^d5^d6^d7.
REQ-022 Codeword layout, bit 11 down to 0: {d7,d6,d5,d4,p3,d3,d2,d1,p2,d0,p1,p0}; bit index i = Hamming position i+1.
REQ-023 If injection was latched with index <12, that codeword bit SHALL be inverted before storage.
REQ-024 WR: array[addr] and o_last_code written; o_wack[n] pulses; next IDLE. Write latency: grant at T, o_wack at T+2.
REQ-025 RD: array[addr] read into a register; next DEC.
REQ-026 DEC: syndrome s = {s3,s2,s1,s0}, each the XOR of the stored bits whose position has that bit set; s=0 pass data; s=1..12 flip bit s-1 and set o_err_corr; s=13..15 leave data uncorrected and set o_err_bad.
REQ-027 DEC: o_rvalid[n], o_rdata, flags registered out; next IDLE. Read latency: grant at T, o_rvalid at T+3.
REQ-028 o_rdata and flags SHALL hold until the next o_rvalid; o_wack and o_rvalid SHALL be single-cycle pulses.
REQ-029 Back-to-back: next grant no earlier than the cycle the FSM re-enters IDLE; read after write to the same address SHALL return the new data.
REQ-030 Addresses wrap modulo 2**ADDR_W; no out-of-range condition exists.

Reset
REQ-031 Asserting i_rst_n low SHALL immediately force IDLE, arbiter pointer to favour 0, o_req_ready/o_wack/o_rvalid/o_err_corr/o_err_bad=0, o_rdata=8'h00, o_last_code=12'h000.
REQ-032 Reset mid-operation SHALL abort it with no o_wack/o_rvalid; array contents are not reset, and an aborted WR-state write is undefined.
REQ-033 First grant SHALL be possible in the first clock edge after reset release.

Verification
REQ-034 Req0 write addr 3 data 8'h11, no inject -> o_req_ready=2'b01 at T, o_wack[0] at T+2, o_last_code=12'h186.
REQ-035 Req1 read addr 3 -> o_rvalid[1] at T+3, o_rdata=8'h11, o_err_corr=0, o_err_bad=0.
REQ-036 Write addr 5 data 8'h11 with inject bit 2 -> o_last_code=12'h182; read addr 5 -> o_rdata=8'h11, o_err_corr=1.
REQ-037 Both requesters valid continuously from reset -> grants alternate 01,10,01,10; neither granted while FSM busy.
REQ-038 Inject bit 15 -> o_last_code unaltered, read o_err_corr=0.
REQ-039 Assert i_rst_n low during RD -> outputs reset instantly, no o_rvalid; after release req0 granted first.
